// File: rtl/vga_arb_pkg.sv
// vga_arb_pkg: shared definitions for the VGA video-RAM arbiter.
//   ADR_W        word-address width of every port (addresses are [ADR_W:1])
//   arb_state_e  arbiter FSM encoding: IDLE, VID (frame read), CPU (control cycle)
package vga_arb_pkg;
  localparam int ADR_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CPU  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if: classic Wishbone master bus from the arbiter to the
// shared video-RAM controller.
//   master modport (arbiter):   drives m_adr_o/m_dat_o/m_sel_o/m_we_o/m_stb_o/m_cyc_o,
//                               receives m_dat_i/m_ack_i
//   slave modport (controller): the mirror image
interface vga_mem_arbiter_if;
  import vga_arb_pkg::*;

  logic [ADR_W:1] m_adr_o;
  logic [15:0]    m_dat_o;
  logic [1:0]     m_sel_o;
  logic           m_we_o;
  logic           m_stb_o;
  logic           m_cyc_o;
  logic [15:0]    m_dat_i;
  logic           m_ack_i;

  modport master (
    output m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o, m_cyc_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o, m_cyc_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/vga_arb_fifo.sv
// vga_arb_fifo: synchronous FIFO holding queued frame-read addresses.
//   clk, rst_n  clock, synchronous active-low reset (empties the FIFO)
//   push, din   write din at the tail; caller must not push when full unless popping
//   pop, dout   dout is the head (valid while !empty); pop advances it
//   full, empty occupancy flags
// Simultaneous push and pop is legal at any fill level; when full the pushed
// word lands in the slot the pop vacates.
module vga_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // one extra pointer bit distinguishes full from empty
  logic [AW:0]      wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: serialises VGA frame reads (queued, priority) and CPU-path
// control cycles onto one classic Wishbone master port.
//   wb_clk_i, wb_rst_ni       clock, synchronous active-low reset
//   v_wbs_adr_i, v_wbs_stb_i  frame-read requests, one per cycle, never stalled
//   v_wbs_dat_o, v_wbs_ack_o  last returned frame word, one-cycle update pulse
//   c_wbs_*                   CPU-path classic slave (ack/data combinational)
//   m                         master bus to the RAM controller (registered outputs)
//   vid_ovf_o                 sticky: a frame-read request was dropped
// Parameters: VFIFO_DEPTH (power of 2, >= 2), MAX_VID_BURST.
// Build option VGA_ARB_CPU_FAIR_EN: after MAX_VID_BURST back-to-back video
// grants while the CPU waits, the next grant goes to the CPU. Without it video
// has strict priority.
module vga_mem_arbiter
  import vga_arb_pkg::*;
#(
  parameter int VFIFO_DEPTH   = 4,
  parameter int MAX_VID_BURST = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [ADR_W:1]      v_wbs_adr_i,
  input  logic                v_wbs_stb_i,
  output logic [15:0]         v_wbs_dat_o,
  output logic                v_wbs_ack_o,
  input  logic [ADR_W:1]      c_wbs_adr_i,
  input  logic [15:0]         c_wbs_dat_i,
  input  logic [1:0]          c_wbs_sel_i,
  input  logic                c_wbs_we_i,
  input  logic                c_wbs_stb_i,
  input  logic                c_wbs_cyc_i,
  output logic [15:0]         c_wbs_dat_o,
  output logic                c_wbs_ack_o,
  vga_mem_arbiter_if.master   m,
  output logic                vid_ovf_o
);
  if (VFIFO_DEPTH < 2 || (VFIFO_DEPTH & (VFIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("VFIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (MAX_VID_BURST < 1) begin : g_bad_burst
    $error("MAX_VID_BURST must be at least 1");
  end

  arb_state_e     state, state_nx;
  logic           req_vld;
  logic [ADR_W:1] req_adr, head;
  logic           push, pop, full, empty;
  logic           cpu_req, grant_vid, grant_cpu, force_cpu;

  assign cpu_req = c_wbs_stb_i & c_wbs_cyc_i;

  // Requests are registered before entering the FIFO; this stage sets the
  // push-to-strobe latency of two edges.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      req_vld <= 1'b0;
      req_adr <= '0;
    end else begin
      req_vld <= v_wbs_stb_i;
      req_adr <= v_wbs_adr_i;
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pop  = (state == ST_VID) & m.m_ack_i;
  assign push = req_vld & (~full | pop);

  vga_arb_fifo #(.DEPTH(VFIFO_DEPTH), .WIDTH(ADR_W)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (push),
    .pop   (pop),
    .din   (req_adr),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef VGA_ARB_CPU_FAIR_EN
  localparam int CW = $clog2(MAX_VID_BURST + 1);
  logic [CW-1:0] burst_cnt;

  assign force_cpu = cpu_req && (burst_cnt == CW'(MAX_VID_BURST));

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni || !cpu_req || grant_cpu) burst_cnt <= '0;
    else if (grant_vid)                      burst_cnt <= burst_cnt + 1'b1;
  end
`else
  assign force_cpu = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !force_cpu) begin
          state_nx  = ST_VID;
          grant_vid = 1'b1;
        end else if (cpu_req) begin
          state_nx  = ST_CPU;
          grant_cpu = 1'b1;
        end
      end
      ST_VID, ST_CPU: if (m.m_ack_i) state_nx = ST_IDLE;
      default:        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state       <= ST_IDLE;
      v_wbs_dat_o <= '0;
      v_wbs_ack_o <= 1'b0;
      vid_ovf_o   <= 1'b0;
      m.m_adr_o   <= '0;
      m.m_dat_o   <= '0;
      m.m_sel_o   <= '0;
      m.m_we_o    <= 1'b0;
      m.m_stb_o   <= 1'b0;
      m.m_cyc_o   <= 1'b0;
    end else begin
      state       <= state_nx;
      v_wbs_ack_o <= pop;
      if (pop) v_wbs_dat_o <= m.m_dat_i;
      if (req_vld && full && !pop) vid_ovf_o <= 1'b1;

      if (grant_vid) begin
        m.m_adr_o <= head;
        m.m_dat_o <= '0;
        m.m_sel_o <= 2'b11;
        m.m_we_o  <= 1'b0;
        m.m_stb_o <= 1'b1;
        m.m_cyc_o <= 1'b1;
      end else if (grant_cpu) begin
        m.m_adr_o <= c_wbs_adr_i;
        m.m_dat_o <= c_wbs_dat_i;
        m.m_sel_o <= c_wbs_sel_i;
        m.m_we_o  <= c_wbs_we_i;
        m.m_stb_o <= 1'b1;
        m.m_cyc_o <= 1'b1;
      end else if (state != ST_IDLE && m.m_ack_i) begin
        m.m_stb_o <= 1'b0;
        m.m_cyc_o <= 1'b0;
      end
    end
  end

  assign c_wbs_ack_o = (state == ST_CPU) & m.m_ack_i;
  assign c_wbs_dat_o = (state == ST_CPU) ? m.m_dat_i : '0;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed scenarios plus a randomized run, all checked
// cycle by cycle against a transaction-level model (address queue + busy flag).
// Honours VGA_ARB_CPU_FAIR_EN for the fairness expectation.
module tb_vga_mem_arbiter;
  import vga_arb_pkg::*;

  localparam int DEPTH = 4;
  localparam int BURST = 2;
`ifdef VGA_ARB_CPU_FAIR_EN
  localparam int CPU_AFTER = BURST;
`else
  localparam int CPU_AFTER = DEPTH;
`endif

  logic           wb_clk_i = 1'b0;
  logic           wb_rst_ni;
  logic [ADR_W:1] v_adr;
  logic           v_stb;
  logic [15:0]    v_dat;
  logic           v_ack;
  logic [ADR_W:1] c_adr;
  logic [15:0]    c_wdat, c_rdat;
  logic [1:0]     c_sel;
  logic           c_we, c_stb, c_cyc, c_ack;
  logic           ovf;

  vga_mem_arbiter_if bus ();

  vga_mem_arbiter #(.VFIFO_DEPTH(DEPTH), .MAX_VID_BURST(BURST)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .v_wbs_adr_i (v_adr),
    .v_wbs_stb_i (v_stb),
    .v_wbs_dat_o (v_dat),
    .v_wbs_ack_o (v_ack),
    .c_wbs_adr_i (c_adr),
    .c_wbs_dat_i (c_wdat),
    .c_wbs_sel_i (c_sel),
    .c_wbs_we_i  (c_we),
    .c_wbs_stb_i (c_stb),
    .c_wbs_cyc_i (c_cyc),
    .c_wbs_dat_o (c_rdat),
    .c_wbs_ack_o (c_ack),
    .m           (bus),
    .vid_ovf_o   (ovf)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_chk = 0, n_pass = 0;

  // reference model
  logic [ADR_W:1] mq[$];
  logic [ADR_W:1] vlog[$];
  bit             busy, busy_cpu, pend_vld;
  logic [ADR_W:1] pend_adr, e_adr;
  logic [15:0]    e_dat, e_vdat;
  logic [1:0]     e_sel;
  bit             e_we, e_vack, e_ovf;
  int             fair_cnt;
  bit             granted_vid, cpu_acked, rst_edge, comb_ok, cpu_cool, last_cack;

  // controller model controls
  int          ack_mode;   // 0 stall, 1 zero-wait, 2 random
  bit          force_ack, use_fix;
  logic [15:0] fix_dat;
  int          vack_cnt, cack_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_edge();
    bit creq, ack, fcpu;
    creq = c_stb && c_cyc;
    ack  = bus.m_ack_i;
    e_vack = 0; cpu_acked = 0; granted_vid = 0;
    if (!wb_rst_ni) begin
      mq.delete();
      busy = 0; busy_cpu = 0; pend_vld = 0; pend_adr = '0;
      e_adr = '0; e_dat = '0; e_sel = '0; e_we = 0; e_vdat = '0; e_ovf = 0;
      fair_cnt = 0; rst_edge = 1;
      return;
    end
    rst_edge = 0;
    if (busy) begin
      if (ack) begin
        busy = 0;
        if (busy_cpu) cpu_acked = 1;
        else begin
          void'(mq.pop_front());
          e_vack = 1;
          e_vdat = bus.m_dat_i;
        end
      end
    end else begin
      fcpu = 0;
`ifdef VGA_ARB_CPU_FAIR_EN
      fcpu = creq && (fair_cnt >= BURST);
`endif
      if (mq.size() > 0 && !fcpu) begin
        busy = 1; busy_cpu = 0; granted_vid = 1;
        e_adr = mq[0]; e_we = 0; e_sel = 2'b11;
        if (creq) fair_cnt++;
      end else if (creq) begin
        busy = 1; busy_cpu = 1;
        e_adr = c_adr; e_dat = c_wdat; e_sel = c_sel; e_we = c_we;
        fair_cnt = 0;
      end
    end
    if (!creq) fair_cnt = 0;
    if (pend_vld) begin
      if (mq.size() < DEPTH) mq.push_back(pend_adr);
      else e_ovf = 1;
    end
    pend_vld = v_stb;
    pend_adr = v_adr;
  endtask

  task automatic tick();
    if (force_ack)          bus.m_ack_i = 1'b1;
    else if (ack_mode == 1) bus.m_ack_i = bus.m_stb_o;
    else if (ack_mode == 2) bus.m_ack_i = bus.m_stb_o ? ($urandom_range(1, 0) == 1)
                                                      : ($urandom_range(7, 0) == 0);
    else                    bus.m_ack_i = 1'b0;
    force_ack = 0;
    bus.m_dat_i = use_fix ? fix_dat : 16'($urandom);
    #1;
    if (comb_ok) begin
      chk("c_ack", c_ack, busy && busy_cpu && bus.m_ack_i);
      chk("c_dat", c_rdat, (busy && busy_cpu) ? bus.m_dat_i : 16'h0);
    end
    last_cack = c_ack;
    @(posedge wb_clk_i);
    model_edge();
    #1;
    if (rst_edge) comb_ok = 1;
    chk("m_stb", bus.m_stb_o, busy);
    chk("m_cyc", bus.m_cyc_o, busy);
    chk("v_ack", v_ack, e_vack);
    chk("v_dat", v_dat, e_vdat);
    chk("ovf", ovf, e_ovf);
    if (busy || rst_edge) begin
      chk("m_adr", bus.m_adr_o, e_adr);
      chk("m_we", bus.m_we_o, e_we);
      chk("m_sel", bus.m_sel_o, e_sel);
      if (busy_cpu || rst_edge) chk("m_dat", bus.m_dat_o, e_dat);
    end
    if (granted_vid) vlog.push_back(bus.m_adr_o);
    if (e_vack) vack_cnt++;
    cpu_cool = 0;
    if (cpu_acked) begin
      cack_cnt++;
      c_stb = 0; c_cyc = 0; cpu_cool = 1;
    end
    v_stb = 0;
  endtask

  task automatic do_reset();
    wb_rst_ni = 0;
    tick();
    wb_rst_ni = 1;
  endtask

  task automatic start_cpu(input logic [ADR_W:1] a, input logic [15:0] d,
                           input logic [1:0] s, input logic w);
    c_adr = a; c_wdat = d; c_sel = s; c_we = w; c_stb = 1; c_cyc = 1;
  endtask

  initial begin
    int vb;
    v_adr = '0; v_stb = 0; c_adr = '0; c_wdat = '0; c_sel = '0; c_we = 0; c_stb = 0; c_cyc = 0;
    bus.m_ack_i = 0; bus.m_dat_i = '0;
    ack_mode = 0; force_ack = 0; use_fix = 0; fix_dat = '0; comb_ok = 0;
    busy = 0; busy_cpu = 0; vack_cnt = 0; cack_cnt = 0;

    // reset state
    wb_rst_ni = 0;
    tick(); tick();
    chk("rst_stb", bus.m_stb_o, 0);
    chk("rst_vdat", v_dat, 0);
    chk("rst_ovf", ovf, 0);
    wb_rst_ni = 1;

    // single video read: strobe after t+2, data/ack after t+3
    ack_mode = 1; use_fix = 1; fix_dat = 16'hA5A5;
    v_stb = 1; v_adr = 17'h00010;
    tick();                                   // edge t
    tick();                                   // t+1
    chk("lat_t1_stb", bus.m_stb_o, 0);
    tick();                                   // t+2
    chk("lat_t2_stb", bus.m_stb_o, 1);
    chk("lat_t2_adr", bus.m_adr_o, 17'h00010);
    tick();                                   // t+3
    chk("lat_t3_ack", v_ack, 1);
    chk("lat_t3_dat", v_dat, 16'hA5A5);
    tick();
    chk("lat_ack_pulse", v_ack, 0);

    // CPU write with FIFO empty
    ack_mode = 0; use_fix = 0;
    start_cpu(17'h1FFFF, 16'h1234, 2'b01, 1'b1);
    tick();
    chk("cpu_adr", bus.m_adr_o, 17'h1FFFF);
    chk("cpu_dat", bus.m_dat_o, 16'h1234);
    chk("cpu_sel", bus.m_sel_o, 2'b01);
    chk("cpu_we", bus.m_we_o, 1);
    tick();
    chk("cpu_ack_wait", last_cack, 0);
    force_ack = 1;
    tick();
    chk("cpu_ack_hi", last_cack, 1);
    chk("cpu_stb_drop", bus.m_stb_o, 0);
    tick();
    chk("cpu_ack_lo", last_cack, 0);

    // overflow: six pushes into a depth-4 FIFO while the controller stalls
    vlog.delete(); vack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      v_stb = 1; v_adr = 17'h00100 + 17'(i);
      tick();
    end
    tick(); tick();
    chk("ovf_set", ovf, 1);
    ack_mode = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("ovf_sticky", ovf, 1);
    chk("ovf_nack", vack_cnt, 4);
    chk("ovf_ngrant", vlog.size(), 4);
    for (int i = 0; i < 4 && i < vlog.size(); i++) chk("ovf_order", vlog[i], 17'h00100 + 17'(i));

    // push and pop in the same cycle while full
    do_reset();
    ack_mode = 0;
    for (int i = 0; i < 4; i++) begin
      v_stb = 1; v_adr = 17'h00300 + 17'(i);
      tick();
    end
    tick();
    v_stb = 1; v_adr = 17'h00304;
    tick();
    force_ack = 1;
    tick();
    chk("pp_ovf", ovf, 0);
    vlog.delete(); vack_cnt = 0; ack_mode = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("pp_nack", vack_cnt, 4);
    chk("pp_ngrant", vlog.size(), 4);
    for (int i = 0; i < 4 && i < vlog.size(); i++) chk("pp_order", vlog[i], 17'h00301 + 17'(i));
    chk("pp_ovf_end", ovf, 0);

    // CPU request against a queue of four video requests
    do_reset();
    ack_mode = 0;
    v_stb = 1; v_adr = 17'h00400; tick();
    v_stb = 1; v_adr = 17'h00401; tick();
    v_stb = 1; v_adr = 17'h00402;
    start_cpu(17'h00AAA, 16'h0, 2'b11, 1'b0);
    tick();
    v_stb = 1; v_adr = 17'h00403; tick();
    tick(); tick();
    vack_cnt = 0; cack_cnt = 0; ack_mode = 1; vb = -1;
    for (int i = 0; i < 40 && cack_cnt == 0; i++) begin
      tick();
      if (cack_cnt != 0) vb = vack_cnt;
    end
    chk("fair_cpu_done", cack_cnt, 1);
    chk("fair_vacks", vb, CPU_AFTER);
    for (int i = 0; i < 20; i++) tick();
    chk("fair_total_vacks", vack_cnt, 4);

    // reset during a video cycle with the ack pending, then late acks
    ack_mode = 0;
    v_stb = 1; v_adr = 17'h00555;
    tick(); tick(); tick();
    chk("rst_pre_stb", bus.m_stb_o, 1);
    wb_rst_ni = 0; force_ack = 1;
    tick();
    chk("rst_mid_stb", bus.m_stb_o, 0);
    chk("rst_mid_adr", bus.m_adr_o, 0);
    chk("rst_mid_vack", v_ack, 0);
    chk("rst_mid_vdat", v_dat, 0);
    wb_rst_ni = 1; vack_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      force_ack = 1;
      tick();
      chk("late_ack_vack", v_ack, 0);
    end
    chk("late_ack_cnt", vack_cnt, 0);

    // randomized traffic
    do_reset();
    ack_mode = 2;
    for (int i = 0; i < 800; i++) begin
      v_stb = ($urandom_range(2, 0) == 0);
      v_adr = 17'($urandom);
      if (!c_stb && !cpu_cool && $urandom_range(5, 0) == 0)
        start_cpu(17'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Two-port Wishbone arbiter between the VGA core's two video-RAM masters and the single shared video-RAM controller port. The VGA core issues fire-and-forget frame reads that cannot stall, plus CPU-path control cycles that can. This block buffers frame-read requests in a small FIFO, gives them priority, and serialises both onto one classic Wishbone master port. The frame-read data register feeds the VGA core's `v_wbm_dat_i`.

## Interface
- `VFIFO_DEPTH`, default 4: frame-read request FIFO entries; must be a power of 2, minimum 2.
- `MAX_VID_BURST`, default 8: consecutive video grants allowed before a forced CPU grant. Used only under `VGA_ARB_CPU_FAIR_EN`.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_ni` in 1: reset, synchronous, active-low.
- `v_wbs_adr_i` in [17:1]: frame-read word address.
- `v_wbs_stb_i` in 1: one read request per cycle high; never stalls.
- `v_wbs_dat_o` out 16: last returned frame word, held until the next return.
- `v_wbs_ack_o` out 1: one-cycle pulse when `v_wbs_dat_o` updates.
- `c_wbs_adr_i` in [17:1], `c_wbs_dat_i` in 16, `c_wbs_sel_i` in 2, `c_wbs_we_i` in 1, `c_wbs_stb_i` in 1, `c_wbs_cyc_i` in 1: CPU-path classic slave.
- `c_wbs_dat_o` out 16, `c_wbs_ack_o` out 1: CPU read data and ack.
- `m_adr_o` out [17:1], `m_dat_o` out 16, `m_sel_o` out 2, `m_we_o` out 1, `m_stb_o` out 1, `m_cyc_o` out 1: master to the RAM controller.
- `m_dat_i` in 16, `m_ack_i` in 1: RAM controller response.
- `vid_ovf_o` out 1: sticky flag set when a frame-read request is dropped.

## Operation
- Request FIFO:
  - Each cycle with `v_wbs_stb_i`=1 pushes `v_wbs_adr_i`.
  - A push when full is dropped, the FIFO is unchanged, and `vid_ovf_o` is set. Only reset clears the flag.
  - Push and pop in the same cycle are legal at any fill level, including full. A pop frees the slot first, so that push succeeds.
- FSM states: IDLE, VID, CPU. All `m_*` outputs are registered.
- IDLE:
  - If the FIFO is non-empty, go to VID. Drive `m_adr_o`=head, `m_we_o`=0, `m_sel_o`=2'b11, `m_stb_o`=`m_cyc_o`=1.
  - Otherwise, if `c_wbs_stb_i & c_wbs_cyc_i`, go to CPU. Register the CPU address, data, sel and we onto `m_*`, and set `m_stb_o`=`m_cyc_o`=1.
  - Otherwise `m_stb_o`=`m_cyc_o`=0.
- VID, on `m_ack_i`:
  - Register `m_dat_i` into `v_wbs_dat_o`.
  - Pulse `v_wbs_ack_o` on the next cycle.
  - Pop the FIFO, drop `m_stb_o`, return to IDLE.
- CPU, on `m_ack_i`:
  - `c_wbs_ack_o` = (state==CPU) & `m_ack_i`, combinational.
  - `c_wbs_dat_o` = `m_dat_i` passthrough.
  - Drop `m_stb_o` and return to IDLE.
  - Outside the CPU state, `c_wbs_ack_o`=0 and `c_wbs_dat_o`=0.
- A CPU cycle in progress is never pre-empted. Video requests queue behind it.
- Reset values: all outputs 0; FIFO empty; state IDLE.
- Reset mid-cycle: the outstanding transfer is abandoned. A late `m_ack_i` arriving in IDLE is ignored.

## Timing
- Every transfer passes through IDLE, so there is exactly one bubble cycle between consecutive master cycles.
- Video latency: push sampled at edge t, `m_stb_o` high after edge t+2. With a zero-wait controller acking in that same cycle, `v_wbs_ack_o` and the new `v_wbs_dat_o` appear after edge t+3.
- CPU latency: with the CPU master already requesting when the FSM enters IDLE, the grant (`m_stb_o`=1) follows one edge later, and the ack is same-cycle with `m_ack_i`.
- The CPU master must hold stb, cyc, adr, dat, sel and we stable until ack, and drop stb on the cycle after ack.
- `m_cyc_o` equals `m_stb_o`, with no multi-cycle locking.

## Configuration
- `VGA_ARB_CPU_FAIR_EN` defined:
  - A counter tracks consecutive VID grants made while CPU was requesting.
  - When the counter reaches `MAX_VID_BURST`, the next IDLE decision grants CPU even if the FIFO is non-empty, and the counter clears.
  - The counter also clears on any CPU grant and whenever CPU is not requesting.
- Undefined: strict video priority. The counter logic is absent.

## Structure
- Package `vga_arb_pkg`: state encoding (IDLE, VID, CPU) and the word-address width constant (17).
- Sub-module `vga_arb_fifo`: synchronous FIFO with push, pop, full and empty, parameterised by depth and width. It performs no overflow detection; the arbiter gates push with full.

## Test plan
- Single video read, adr 17'h00010; controller returns 16'hA5A5 with zero wait → `m_adr_o`=17'h00010 after edge t+2; `v_wbs_dat_o`=16'hA5A5 and a one-cycle `v_wbs_ack_o` after edge t+3.
- CPU write adr 17'h1FFFF, dat 16'h1234, sel 2'b01, with the FIFO empty → master shows those values, `m_we_o`=1; `c_wbs_ack_o` is high only in the `m_ack_i` cycle.
- Video pushes of 17'h00100..17'h00105 on consecutive cycles while the controller stalls, with depth 4 → `vid_ovf_o`=1; only pushes that find the FIFO full are dropped, and queued addresses are issued in order.
- CPU request while 4 video requests are queued:
  - Strict build: CPU is granted after the 4th video ack.
  - With `VGA_ARB_CPU_FAIR_EN` and `MAX_VID_BURST`=2: CPU is granted after the 2nd video ack.
- `wb_rst_ni`=0 during VID with `m_ack_i` pending → all outputs 0 on the next edge; a later `m_ack_i` produces no `v_wbs_ack_o`.
- Push and pop in the same cycle with the FIFO full → no overflow, and the occupancy stays at 4.
